// File: rtl/regex_job_sequencer.sv
// Job sequencer for a register-mapped regex engine: takes one job (tag plus a
// string byte range), programs the engine pointers, issues START, watches
// the engine status until it finishes, reads the elapsed clock count and
// hands the result to a consumer. Start and run phases are both bounded by
// timeouts, so a dead or misbehaving engine always yields an error result.
//
// Handshakes (job_* and res_*): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and its payload
// stable until that edge. Neither ready nor valid depends combinationally on
// the other side's signal; both are decoded from the registered state only.
module regex_job_sequencer #(
  parameter int REG_WIDTH     = 32,
  parameter int TAG_W         = 8,
  parameter int START_TIMEOUT = 8,
  parameter int RUN_TIMEOUT   = 2**20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [TAG_W-1:0]     job_tag,
  input  logic [REG_WIDTH-1:0] job_start_ptr,
  input  logic [REG_WIDTH-1:0] job_end_ptr,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_accept,
  output logic                 res_error,
  output logic [REG_WIDTH-1:0] res_cycles,
  output logic                 busy
);

  // Engine command and status encodings.
  localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(4);

  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = REG_WIDTH'(3);

  // Start counter only has to reach START_TIMEOUT-1; run counter saturates
  // at RUN_TIMEOUT itself.
  localparam int SCW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int RCW = $clog2(RUN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    READ_CC = 3'd4,
    CAPTURE = 3'd5,
    RESULT  = 3'd6
  } state_t;

  // Exposed by name so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [TAG_W-1:0]     tag_q;
  logic [REG_WIDTH-1:0] start_ptr_q;
  logic [REG_WIDTH-1:0] end_ptr_q;
  logic [SCW-1:0]       start_cnt;
  logic [RCW-1:0]       run_cnt;
  logic [REG_WIDTH-1:0] cmd_next;

  logic job_take;
  logic load_ptrs;
  logic start_inc;
  logic run_inc;
  logic run_sat;
  logic set_accept;
  logic set_reject;
  logic set_error;
  logic capture;

  assign job_ready = (state == IDLE);
  assign res_valid = (state == RESULT);
  assign busy      = (state != IDLE);
  assign res_tag   = tag_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_next = state;
    cmd_next   = cmd_register;
    job_take   = 1'b0;
    load_ptrs  = 1'b0;
    start_inc  = 1'b0;
    run_inc    = 1'b0;
    run_sat    = 1'b0;
    set_accept = 1'b0;
    set_reject = 1'b0;
    set_error  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (job_valid) begin
          job_take   = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        load_ptrs  = 1'b1;
        cmd_next   = CMD_NOP;
        state_next = START;
      end
      START: begin
        if (status_register == STATUS_RUNNING) begin
          cmd_next   = CMD_NOP;
          state_next = RUN;
        end else if (start_cnt == SCW'(START_TIMEOUT - 1)) begin
          set_error  = 1'b1;
          cmd_next   = CMD_NOP;
          state_next = RESULT;
        end else begin
          cmd_next  = CMD_START;
          start_inc = 1'b1;
        end
      end
      RUN: begin
        cmd_next = CMD_NOP;
        if (status_register == STATUS_RUNNING) begin
          if (run_cnt >= RCW'(RUN_TIMEOUT - 1)) begin
            run_sat    = 1'b1;
            set_error  = 1'b1;
            state_next = RESULT;
          end else begin
            run_inc = 1'b1;
          end
        end else if (status_register == STATUS_ACCEPTED) begin
          set_accept = 1'b1;
          state_next = READ_CC;
        end else if (status_register == STATUS_REJECTED) begin
          set_reject = 1'b1;
          state_next = READ_CC;
        end else begin
          set_error  = 1'b1;
          state_next = RESULT;
        end
      end
      READ_CC: begin
        cmd_next   = CMD_READ_ELAPSED_CLOCK;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        capture    = 1'b1;
        cmd_next   = CMD_NOP;
        state_next = RESULT;
      end
      RESULT: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job latch, engine register file, counters and result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q                     <= '0;
      start_ptr_q               <= '0;
      end_ptr_q                 <= '0;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
      cmd_register              <= CMD_NOP;
      start_cnt                 <= '0;
      run_cnt                   <= '0;
      res_accept                <= 1'b0;
      res_error                 <= 1'b0;
      res_cycles                <= '0;
    end else begin
      cmd_register <= cmd_next;
      if (job_take) begin
        tag_q       <= job_tag;
        start_ptr_q <= job_start_ptr;
        end_ptr_q   <= job_end_ptr;
        start_cnt   <= '0;
        run_cnt     <= '0;
        res_accept  <= 1'b0;
        res_error   <= 1'b0;
        res_cycles  <= '0;
      end
      if (load_ptrs) begin
        start_cc_pointer_register <= start_ptr_q;
        end_cc_pointer_register   <= end_ptr_q;
      end
      if (start_inc) start_cnt <= start_cnt + 1'b1;
      if (run_inc)   run_cnt   <= run_cnt + 1'b1;
      if (run_sat)   run_cnt   <= RCW'(RUN_TIMEOUT);
      if (set_accept) res_accept <= 1'b1;
      if (set_reject) res_accept <= 1'b0;
      if (capture)    res_cycles <= data_o_register;
      if (set_error) begin
        res_error  <= 1'b1;
        res_accept <= 1'b0;
        res_cycles <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regex_job_sequencer.sv
// Bench for regex_job_sequencer: a behavioural engine model, a table of
// single-job vectors with hand-computed results and latencies, and directed
// sequences for result hold, reset mid-job and back-to-back jobs.
module tb_regex_job_sequencer;

  localparam int RW = 32;
  localparam int TW = 8;

  localparam logic [RW-1:0] CMD_NOP        = 32'd0;
  localparam logic [RW-1:0] CMD_START      = 32'd3;
  localparam logic [RW-1:0] CMD_READ_ELAPS = 32'd4;
  localparam logic [RW-1:0] ST_IDLE        = 32'd0;
  localparam logic [RW-1:0] ST_RUNNING     = 32'd1;
  localparam logic [RW-1:0] ST_ACCEPTED    = 32'd2;
  localparam logic [RW-1:0] ST_REJECTED    = 32'd3;
  localparam logic [RW-1:0] ST_ERROR       = 32'd4;

  localparam int M_ACCEPT  = 0;
  localparam int M_REJECT  = 1;
  localparam int M_SILENT  = 2;
  localparam int M_STUCK   = 3;
  localparam int M_ILLEGAL = 4;

  logic          clk;
  logic          rst_n;
  logic          job_valid;
  logic          job_ready;
  logic [TW-1:0] job_tag;
  logic [RW-1:0] job_start_ptr;
  logic [RW-1:0] job_end_ptr;
  logic [RW-1:0] start_cc_pointer_register;
  logic [RW-1:0] end_cc_pointer_register;
  logic [RW-1:0] cmd_register;
  logic [RW-1:0] eng_status;
  logic [RW-1:0] eng_data;
  logic          res_valid;
  logic          res_ready;
  logic [TW-1:0] res_tag;
  logic          res_accept;
  logic          res_error;
  logic [RW-1:0] res_cycles;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = -1;
  int eng_mode = M_ACCEPT;
  int eng_len = 1;
  int eng_cnt = 0;

  regex_job_sequencer #(
    .REG_WIDTH(RW), .TAG_W(TW), .START_TIMEOUT(8), .RUN_TIMEOUT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
    .job_start_ptr(job_start_ptr), .job_end_ptr(job_end_ptr),
    .start_cc_pointer_register(start_cc_pointer_register),
    .end_cc_pointer_register(end_cc_pointer_register),
    .cmd_register(cmd_register), .status_register(eng_status),
    .data_o_register(eng_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_accept(res_accept), .res_error(res_error), .res_cycles(res_cycles),
    .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Engine model: goes RUNNING the cycle after it first sees CMD_START,
  // reports its final status after eng_len RUNNING cycles, and drops back to
  // idle on result handoff or reset. cyc indexes the cycle starting at this edge.
  always @(posedge clk) begin
    logic [RW-1:0] cmd_seen;
    logic          handoff;
    cmd_seen = cmd_register;
    handoff  = res_valid && res_ready;
    cyc = cyc + 1;
    #1;
    if (!rst_n || handoff) begin
      eng_status = ST_IDLE;
      eng_cnt = 0;
    end else if (eng_status == ST_RUNNING && eng_mode != M_STUCK) begin
      eng_cnt = eng_cnt + 1;
      if (eng_cnt == eng_len) begin
        done_cyc = cyc;
        if (eng_mode == M_ACCEPT)      eng_status = ST_ACCEPTED;
        else if (eng_mode == M_REJECT) eng_status = ST_REJECTED;
        else                           eng_status = ST_ERROR;
      end
    end else if (eng_status != ST_RUNNING && cmd_seen == CMD_START && eng_mode != M_SILENT) begin
      eng_status = ST_RUNNING;
      eng_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [TW-1:0] tag;
    logic [RW-1:0] sp;
    logic [RW-1:0] ep;
    int            mode;
    int            len;
    logic [RW-1:0] data;
    int            hold;
    logic          exp_acc;
    logic          exp_err;
    logic [RW-1:0] exp_cyc;
    int            exp_vlat;   // acceptance cycle -> first res_valid cycle
    int            exp_dlat;   // engine final status -> res_valid (0 = n/a)
    logic          exp_read;   // CMD_READ_ELAPSED_CLOCK expected
  } vec_t;

  vec_t vecs[7];

  // Driver: offer one job, follow it to its result, hold, then hand off.
  task automatic run_vec(input vec_t v, input string nm);
    int  acc_cyc;
    int  start_cyc;
    int  res_cyc;
    logic read_seen;
    @(negedge clk);
    eng_mode = v.mode;
    eng_len  = v.len;
    eng_data = v.data;
    done_cyc = -1;
    job_valid = 1'b1;
    job_tag = v.tag;
    job_start_ptr = v.sp;
    job_end_ptr = v.ep;
    check({nm, " job_ready idle"}, 32'(job_ready), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    job_valid = 1'b0;
    check({nm, " busy after accept"}, 32'(busy), 32'd1);
    check({nm, " job_ready busy"}, 32'(job_ready), 32'd0);
    start_cyc = -1;
    res_cyc = -1;
    read_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_register == CMD_START && start_cyc < 0) start_cyc = cyc;
      if (cmd_register == CMD_READ_ELAPS) read_seen = 1'b1;
      if (res_valid) begin
        res_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (res_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s res_valid timeout: got none expected within 400 cycles", nm);
    end else begin
      check({nm, " result latency"}, 32'(res_cyc - acc_cyc), 32'(v.exp_vlat));
      check({nm, " start cmd latency"}, 32'(start_cyc - acc_cyc), 32'd3);
      if (v.exp_dlat != 0)
        check({nm, " done->valid"}, 32'(res_cyc - done_cyc), 32'(v.exp_dlat));
      check({nm, " read issued"}, 32'(read_seen), 32'(v.exp_read));
      check({nm, " res_tag"}, 32'(res_tag), 32'(v.tag));
      check({nm, " res_accept"}, 32'(res_accept), 32'(v.exp_acc));
      check({nm, " res_error"}, 32'(res_error), 32'(v.exp_err));
      check({nm, " res_cycles"}, res_cycles, v.exp_cyc);
      check({nm, " cmd at result"}, cmd_register, CMD_NOP);
      check({nm, " start ptr"}, start_cc_pointer_register, v.sp);
      check({nm, " end ptr"}, end_cc_pointer_register, v.ep);
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        check({nm, " hold res_valid"}, 32'(res_valid), 32'd1);
        check({nm, " hold res_tag"}, 32'(res_tag), 32'(v.tag));
        check({nm, " hold res_accept"}, 32'(res_accept), 32'(v.exp_acc));
        check({nm, " hold res_error"}, 32'(res_error), 32'(v.exp_err));
        check({nm, " hold res_cycles"}, res_cycles, v.exp_cyc);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({nm, " res_valid after handoff"}, 32'(res_valid), 32'd0);
      check({nm, " job_ready after handoff"}, 32'(job_ready), 32'd1);
    end
  endtask

  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] b2b_tags[4];

  initial begin
    // Directed table: tag, sp, ep, mode, len, data, hold, acc, err, cycles, vlat, dlat, read
    vecs[0] = '{8'h05, 32'h40, 32'h4F, M_ACCEPT, 20, 32'd20, 0, 1'b1, 1'b0, 32'd20, 27, 3, 1'b1};
    vecs[1] = '{8'h05, 32'h40, 32'h4F, M_REJECT, 20, 32'd20, 5, 1'b0, 1'b0, 32'd20, 27, 3, 1'b1};
    vecs[2] = '{8'hA7, 32'h100, 32'h1FF, M_SILENT, 1, 32'd77, 1, 1'b0, 1'b1, 32'd0, 10, 0, 1'b0};
    vecs[3] = '{8'h3C, 32'h0, 32'hFFF, M_STUCK, 1, 32'd55, 0, 1'b0, 1'b1, 32'd0, 105, 0, 1'b0};
    vecs[4] = '{8'hFF, 32'h1, 32'hFFFFFFFF, M_ACCEPT, 1, 32'hDEADBEEF, 0, 1'b1, 1'b0, 32'hDEADBEEF, 8, 3, 1'b1};
    vecs[5] = '{8'h81, 32'h13, 32'h12, M_ILLEGAL, 4, 32'd9, 0, 1'b0, 1'b1, 32'd0, 9, 1, 1'b0};
    vecs[6] = '{8'h66, 32'h200, 32'h20A, M_ACCEPT, 5, 32'd5, 0, 1'b1, 1'b0, 32'd5, 12, 3, 1'b1};
    b2b_tags[0] = 8'h11;
    b2b_tags[1] = 8'h22;
    b2b_tags[2] = 8'h33;
    b2b_tags[3] = 8'h44;

    job_valid = 1'b0;
    job_tag = '0;
    job_start_ptr = '0;
    job_end_ptr = '0;
    res_ready = 1'b0;
    eng_status = ST_IDLE;
    eng_data = '0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset job_ready", 32'(job_ready), 32'd1);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset cmd", cmd_register, CMD_NOP);
    check("reset start ptr", start_cc_pointer_register, 32'd0);
    check("reset end ptr", end_cc_pointer_register, 32'd0);
    check("reset res_cycles", res_cycles, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of RUN discards the job.
    @(negedge clk);
    eng_mode = M_ACCEPT;
    eng_len = 50;
    eng_data = 32'd50;
    job_tag = 8'h9A;
    job_start_ptr = 32'h300;
    job_end_ptr = 32'h3FF;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun busy", 32'(busy), 32'd1);
    check("midrun engine running", eng_status, ST_RUNNING);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst job_ready", 32'(job_ready), 32'd1);
    check("midrst res_valid", 32'(res_valid), 32'd0);
    check("midrst cmd", cmd_register, CMD_NOP);
    check("midrst start ptr", start_cc_pointer_register, 32'd0);
    check("midrst end ptr", end_cc_pointer_register, 32'd0);
    check("midrst res_tag", 32'(res_tag), 32'd0);
    check("midrst res_accept", 32'(res_accept), 32'd0);
    check("midrst res_error", 32'(res_error), 32'd0);
    check("midrst res_cycles", res_cycles, 32'd0);
    repeat (2) @(negedge clk);
    check("midrst no result", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    run_vec(vecs[6], "after_reset");

    // Back-to-back jobs with job_valid held and res_ready tied high.
    begin
      int n_sent;
      int n_got;
      n_sent = 0;
      n_got = 0;
      @(negedge clk);
      eng_mode = M_ACCEPT;
      eng_len = 3;
      eng_data = 32'd100;
      res_ready = 1'b1;
      job_tag = b2b_tags[0];
      job_start_ptr = 32'h500;
      job_end_ptr = 32'h50F;
      job_valid = 1'b1;
      for (int i = 0; i < 600 && n_got < 4; i++) begin
        if (res_valid) begin
          check("b2b job_ready during handoff", 32'(job_ready), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b2b extra result: got tag 0x%0h expected none", res_tag);
          end else begin
            check("b2b res_tag", 32'(res_tag), 32'(exp_q.pop_front()));
            check("b2b res_accept", 32'(res_accept), 32'd1);
            check("b2b res_cycles", res_cycles, 32'd100);
          end
          n_got++;
        end
        if (job_valid && job_ready) begin
          exp_q.push_back(job_tag);
          n_sent++;
        end
        @(negedge clk);
        if (n_sent >= 4) job_valid = 1'b0;
        else             job_tag = b2b_tags[n_sent];
      end
      res_ready = 1'b0;
      check("b2b jobs sent", 32'(n_sent), 32'd4);
      check("b2b results got", 32'(n_got), 32'd4);
      check("b2b queue empty", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      check("b2b no stray result", 32'(res_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regex_job_sequencer.md
REGEX_JOB_SEQUENCER -- requirements
Module: regex_job_sequencer

Interface
REQ-001 SHALL have parameters: REG_WIDTH, default 32, width of all engine register ports; TAG_W, default 8, job tag width; START_TIMEOUT, default 8, max cycles for START acknowledge; RUN_TIMEOUT, default 2**20, max cycles in RUNNING.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  sequencer accepts job.
- job_tag  in  TAG_W  job identifier.
- job_start_ptr  in  REG_WIDTH  string start byte address.
- job_end_ptr  in  REG_WIDTH  string last byte address.
- start_cc_pointer_register  out  REG_WIDTH  to engine.
- end_cc_pointer_register  out  REG_WIDTH  to engine.
- cmd_register  out  REG_WIDTH  engine command (AXI_package CMD_* codes).
- status_register  in  REG_WIDTH  engine status (STATUS_* codes).
- data_o_register  in  REG_WIDTH  engine read data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_tag  out  TAG_W  tag of finished job.
- res_accept  out  1  1 = STATUS_ACCEPTED, 0 = rejected or error.
- res_error  out  1  timeout or illegal status.
- res_cycles  out  REG_WIDTH  elapsed clock count read from engine; 0 on error.
- busy  out  1  state != IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, START, RUN, READ_CC, CAPTURE, RESULT.
REQ-004 IDLE: job_ready=1; on job_valid&&job_ready SHALL latch tag/pointers and go to SETUP; job_ready SHALL be 0 in every other state.
REQ-005 SETUP (1 cycle): start_cc_pointer_register<=job_start_ptr, end_cc_pointer_register<=job_end_ptr, cmd_register<=CMD_NOP; next START.
REQ-006 START: cmd_register<=CMD_START; when status_register==STATUS_RUNNING SHALL set cmd_register<=CMD_NOP and go to RUN.
REQ-007 START SHALL count cycles; reaching START_TIMEOUT without RUNNING SHALL set error, cmd_register<=CMD_NOP, go to RESULT.
REQ-008 RUN: cmd_register==CMD_NOP; SHALL increment a run counter each cycle status==STATUS_RUNNING.
REQ-009 RUN: status==STATUS_ACCEPTED SHALL latch accept=1; STATUS_REJECTED SHALL latch accept=0; either goes to READ_CC.
REQ-010 RUN: any status other than RUNNING/ACCEPTED/REJECTED SHALL set error and go to RESULT.
REQ-011 RUN: run counter reaching RUN_TIMEOUT SHALL set error and go to RESULT; counter saturates, never wraps.
REQ-012 READ_CC (1 cycle): cmd_register<=CMD_READ_ELAPSED_CLOCK; next CAPTURE.
REQ-013 CAPTURE (1 cycle): SHALL latch data_o_register into res_cycles, cmd_register<=CMD_NOP; next RESULT.
REQ-014 RESULT: res_valid=1 with stable res_* until res_ready; on res_valid&&res_ready SHALL clear res_valid and go to IDLE.
REQ-015 Error results SHALL have res_error=1, res_accept=0, res_cycles=0.
REQ-016 res_valid SHALL not depend combinationally on res_ready; job_ready SHALL not depend combinationally on job_valid.
REQ-017 Job acceptance to START entry latency SHALL be exactly 2 cycles; engine done to res_valid SHALL be exactly 3 cycles.
REQ-018 New job SHALL not be accepted in the same cycle a result is handed off (IDLE entered first).
REQ-019 Pointers SHALL be passed unmodified; no alignment or range check.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, cmd_register=CMD_NOP, pointer registers=0, res_valid=0, res_tag/res_accept/res_error/res_cycles=0, counters=0, busy=0.
REQ-021 Reset mid-job SHALL discard the job; no result produced; first job after release handled normally.

Verification
REQ-022 Job tag 0x05, ptrs 0x40/0x4F; engine RUNNING 1 cycle after CMD_START, ACCEPTED after 20 cycles, data_o=20 -> res_tag=0x05, res_accept=1, res_error=0, res_cycles=20.
REQ-023 Same job, engine REJECTED -> res_accept=0, res_error=0; res_valid held 5 cycles with res_ready=0, all res_* stable.
REQ-024 Engine never reports RUNNING -> after START_TIMEOUT=8 cycles res_error=1, res_cycles=0, cmd_register back to CMD_NOP.
REQ-025 RUN_TIMEOUT=100, engine stuck RUNNING -> res_error=1 exactly after 100 RUN cycles; no CMD_READ_ELAPSED_CLOCK issued.
REQ-026 rst_n pulsed low during RUN -> outputs at reset values immediately; following job completes with correct tag/result.
REQ-027 Back-to-back jobs with job_valid held high and res_ready=1 -> one job per result, tags in order, no duplicated or lost result.
